counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The module SHALL have parameter SIZE, default 8, the width of both counter lanes and the sum.
REQ-002 The module SHALL have parameter THRESH, default 8, the unsigned sum limit that triggers reload.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port start  input  1  begin a run; sampled only in IDLE.
REQ-006 The module SHALL have port stop  input  1  abort a run; sampled in LOAD, RUN and RELOAD.
REQ-007 The module SHALL have ports req1, req2  input  1 each  increment requests for lane 1 and lane 2.
REQ-008 The module SHALL have ports init1, init2  input  SIZE each  reload values for lane 1 and lane 2.
REQ-009 The module SHALL have ports val1, val2  output  SIZE each  registered lane counts.
REQ-010 The module SHALL have port sum  output  SIZE  val1+val2 mod 2^SIZE, combinational.
REQ-011 The module SHALL have ports gnt1, gnt2  output  1 each  combinational grants to the shared incrementer.
REQ-012 The module SHALL have port wrap  output  1  registered one-cycle pulse marking a threshold reload.
REQ-013 The module SHALL have port state  output  2  FSM encoding: IDLE=00, LOAD=01, RUN=10, RELOAD=11.

Function
REQ-014 The FSM SHALL move from IDLE to LOAD on start=1; otherwise it SHALL hold IDLE with counters unchanged.
REQ-015 LOAD SHALL last exactly one cycle, load val1<=init1 and val2<=init2, then enter RUN.
REQ-016 In RUN, at most one grant SHALL be high per cycle; gnt1|gnt2 SHALL be 0 outside RUN.
REQ-017 Arbitration SHALL be round-robin using a 1-bit priority pointer: if both requests are high, the lane named by the pointer wins and the pointer then moves to the other lane; a single requester always wins; the pointer holds when there is no grant.
REQ-018 The granted lane SHALL increment by 1 at the clock edge ending the grant cycle, wrapping modulo 2^SIZE (e.g. 8'hFF -> 8'h00); the other lane holds.
REQ-019 The sum SHALL be unsigned, truncated to SIZE bits, and compared unsigned as sum > THRESH (strictly greater).
REQ-020 In RUN, if sum > THRESH, the FSM SHALL enter RELOAD next cycle and issue no grant in the current cycle.
REQ-021 RELOAD SHALL last one cycle: load val1<=init1 and val2<=init2, reset the pointer to lane 1, assert wrap during exactly this cycle, then return to RUN.
REQ-022 stop=1 in LOAD, RUN or RELOAD SHALL force IDLE next cycle with counters held, overriding both the threshold condition and the grants in that cycle (no increment, no reload).
REQ-023 start SHALL be ignored outside IDLE; start and stop together in IDLE SHALL enter LOAD.
REQ-024 If the init values already satisfy sum > THRESH, the FSM SHALL cycle RUN->RELOAD indefinitely, with wrap pulsing every second cycle, until stop is asserted.

Reset
REQ-025 While rst=1, asynchronously: state=IDLE, val1=0, val2=0, pointer=lane 1, wrap=0, gnt1=gnt2=0.
REQ-026 Reset asserted mid-run SHALL abandon the run immediately with no pending increment or reload; after release the FSM SHALL wait in IDLE for start.

Verification
REQ-027 SIZE=8, THRESH=8, init1=0, init2=1; start pulse; req1=1 only -> LOAD, then RUN; val1 counts 0..8 while sum goes 1..9; sum=9 -> RELOAD, wrap=1 for one cycle, val1=0, val2=1.
REQ-028 req1=req2=1 held in RUN, values as above -> grants alternate gnt1,gnt2,gnt1,...; lanes differ by at most 1; after RELOAD the first grant is gnt1.
REQ-029 THRESH=255, init1=8'hFE, init2=0, req1 only -> val1 goes FE, FF, 00; sum goes FE, FF, 00; no wrap pulse.
REQ-030 stop asserted in the same cycle that sum > THRESH -> next state IDLE, wrap stays 0, counters hold their values.
REQ-031 rst asserted during RUN with val1=5 -> val1=0, state=00 immediately, without waiting for a clock edge; start is then required to resume.
REQ-032 init1=9, init2=0, THRESH=8 -> after LOAD, the state alternates RUN/RELOAD and wrap toggles every second cycle until stop.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: two SIZE-bit counter lanes sharing one incrementer through a
// round-robin arbiter. A small FSM (IDLE/LOAD/RUN/RELOAD) loads both lanes from
// init1/init2 and reloads them whenever their truncated sum exceeds THRESH.
//
// Handshake: req1/req2 are level requests with no ready/ack back-pressure. A
// request is served in a cycle exactly when its gnt is high in that cycle, and
// the granted lane increments at the closing clock edge. A request that is not
// granted simply stays pending for as long as it is held high.
module counter_sched #(
   parameter int SIZE   = 8,
   parameter int THRESH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   input  logic            req1,
   input  logic            req2,
   input  logic [SIZE-1:0] init1,
   input  logic [SIZE-1:0] init2,
   output logic [SIZE-1:0] val1,
   output logic [SIZE-1:0] val2,
   output logic [SIZE-1:0] sum,
   output logic            gnt1,
   output logic            gnt2,
   output logic            wrap,
   output logic [1:0]      state
);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_LOAD   = 2'b01;
   localparam logic [1:0] S_RUN    = 2'b10;
   localparam logic [1:0] S_RELOAD = 2'b11;

   // Threshold held as a 32-bit unsigned constant so the compare is unsigned.
   localparam logic [31:0] THRESH_U = THRESH;

   logic [1:0]      r_state;
   logic [SIZE-1:0] r_val1;
   logic [SIZE-1:0] r_val2;
   logic            r_ptr;   // 0 = lane 1 has priority, 1 = lane 2
   logic            r_wrap;

   logic [1:0]      w_next;
   logic [SIZE-1:0] w_sum;
   logic            w_over;
   logic            w_gnt_en;
   logic            w_gnt1;
   logic            w_gnt2;
   logic            w_load;

   assign w_sum  = r_val1 + r_val2;
   assign w_over = {{(32-SIZE){1'b0}}, w_sum} > THRESH_U;

   // Grants only in RUN; stop and the threshold both suppress them.
   assign w_gnt_en = (r_state == S_RUN) && !stop && !w_over;
   assign w_gnt1   = w_gnt_en && req1 && (!req2 || !r_ptr);
   assign w_gnt2   = w_gnt_en && req2 && (!req1 ||  r_ptr);

   // LOAD and RELOAD both copy the init values unless stop aborts them.
   assign w_load = ((r_state == S_LOAD) || (r_state == S_RELOAD)) && !stop;

   // Next-state decode; stop takes precedence over the threshold in RUN.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_LOAD;
         S_LOAD:   w_next = stop ? S_IDLE : S_RUN;
         S_RUN: begin
            if (stop)        w_next = S_IDLE;
            else if (w_over) w_next = S_RELOAD;
         end
         S_RELOAD: w_next = stop ? S_IDLE : S_RUN;
         default:  w_next = S_IDLE;
      endcase
   end

   // FSM state and the wrap pulse, which is high exactly while in RELOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wrap  <= (w_next == S_RELOAD);
      end
   end

   // Lane counters: load from init, or increment the granted lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_val1 <= '0;
         r_val2 <= '0;
      end else if (w_load) begin
         r_val1 <= init1;
         r_val2 <= init2;
      end else begin
         if (w_gnt1) r_val1 <= r_val1 + SIZE'(1);
         if (w_gnt2) r_val2 <= r_val2 + SIZE'(1);
      end
   end

   // Round-robin pointer: after a grant it points at the other lane; RELOAD
   // hands priority back to lane 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if ((r_state == S_RELOAD) && !stop) begin
         r_ptr <= 1'b0;
      end else if (w_gnt1) begin
         r_ptr <= 1'b1;
      end else if (w_gnt2) begin
         r_ptr <= 1'b0;
      end
   end

   assign val1  = r_val1;
   assign val2  = r_val2;
   assign sum   = w_sum;
   assign gnt1  = w_gnt1;
   assign gnt2  = w_gnt2;
   assign wrap  = r_wrap;
   assign state = r_state;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: two instances (THRESH=8 and THRESH=255) share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_counter_sched;

   localparam int SIZE = 8;
   localparam int MOD  = 256;

   // Mode codes as published in the state table.
   localparam int M_IDLE   = 0;
   localparam int M_LOAD   = 1;
   localparam int M_RUN    = 2;
   localparam int M_RELOAD = 3;

   logic            clk;
   logic            rst;
   logic            start;
   logic            stop;
   logic            req1;
   logic            req2;
   logic [SIZE-1:0] init1;
   logic [SIZE-1:0] init2;

   logic [SIZE-1:0] val1_w [2];
   logic [SIZE-1:0] val2_w [2];
   logic [SIZE-1:0] sum_w  [2];
   logic            gnt1_w [2];
   logic            gnt2_w [2];
   logic            wrap_w [2];
   logic [1:0]      state_w[2];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, one entry per instance.
   int m_mode[2];
   int m_v1[2];
   int m_v2[2];
   int m_ptr[2];     // lane number (1 or 2) that wins a tie
   int m_thr[2];

   counter_sched #(.SIZE(SIZE), .THRESH(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .req1(req1), .req2(req2), .init1(init1), .init2(init2),
      .val1(val1_w[0]), .val2(val2_w[0]), .sum(sum_w[0]),
      .gnt1(gnt1_w[0]), .gnt2(gnt2_w[0]), .wrap(wrap_w[0]), .state(state_w[0])
   );

   counter_sched #(.SIZE(SIZE), .THRESH(255)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .req1(req1), .req2(req2), .init1(init1), .init2(init2),
      .val1(val1_w[1]), .val2(val2_w[1]), .sum(sum_w[1]),
      .gnt1(gnt1_w[1]), .gnt2(gnt2_w[1]), .wrap(wrap_w[1]), .state(state_w[1])
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE;
         m_v1[k]   = 0;
         m_v2[k]   = 0;
         m_ptr[k]  = 1;
      end
   endtask

   function automatic int model_sum(input int k);
      return (m_v1[k] + m_v2[k]) % MOD;
   endfunction

   // Which lane (0 = none) the shared incrementer serves this cycle.
   function automatic int model_winner(input int k);
      if (rst || m_mode[k] != M_RUN || stop || model_sum(k) > m_thr[k]) return 0;
      if (req1 && req2) return m_ptr[k];
      if (req1) return 1;
      if (req2) return 2;
      return 0;
   endfunction

   // Advance the model across one rising edge using the held inputs.
   task automatic model_edge();
      int win;
      for (int k = 0; k < 2; k++) begin
         win = model_winner(k);
         if (rst) begin
            m_mode[k] = M_IDLE; m_v1[k] = 0; m_v2[k] = 0; m_ptr[k] = 1;
         end else begin
            case (m_mode[k])
               M_IDLE: if (start) m_mode[k] = M_LOAD;
               M_LOAD: begin
                  if (stop) m_mode[k] = M_IDLE;
                  else begin
                     m_v1[k] = init1; m_v2[k] = init2; m_mode[k] = M_RUN;
                  end
               end
               M_RUN: begin
                  if (stop) m_mode[k] = M_IDLE;
                  else if (model_sum(k) > m_thr[k]) m_mode[k] = M_RELOAD;
                  else if (win == 1) begin
                     m_v1[k] = (m_v1[k] + 1) % MOD; m_ptr[k] = 2;
                  end else if (win == 2) begin
                     m_v2[k] = (m_v2[k] + 1) % MOD; m_ptr[k] = 1;
                  end
               end
               default: begin
                  if (stop) m_mode[k] = M_IDLE;
                  else begin
                     m_v1[k] = init1; m_v2[k] = init2; m_ptr[k] = 1;
                     m_mode[k] = M_RUN;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic check_outputs();
      int win;
      for (int k = 0; k < 2; k++) begin
         win = model_winner(k);
         check_val($sformatf("val1[%0d]", k),  int'(val1_w[k]),  m_v1[k]);
         check_val($sformatf("val2[%0d]", k),  int'(val2_w[k]),  m_v2[k]);
         check_val($sformatf("sum[%0d]", k),   int'(sum_w[k]),   model_sum(k));
         check_val($sformatf("gnt1[%0d]", k),  int'(gnt1_w[k]),  (win == 1) ? 1 : 0);
         check_val($sformatf("gnt2[%0d]", k),  int'(gnt2_w[k]),  (win == 2) ? 1 : 0);
         check_val($sformatf("wrap[%0d]", k),  int'(wrap_w[k]),  (m_mode[k] == M_RELOAD) ? 1 : 0);
         check_val($sformatf("state[%0d]", k), int'(state_w[k]), m_mode[k]);
      end
   endtask

   // Driver: inputs already set at the falling edge; check, clock, advance.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_inputs(input logic s, input logic p, input logic r1, input logic r2);
      start = s; stop = p; req1 = r1; req2 = r2;
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         check_val("async_rst_state", int'(state_w[k]), M_IDLE);
         check_val("async_rst_val1", int'(val1_w[k]), 0);
         check_val("async_rst_val2", int'(val2_w[k]), 0);
         check_val("async_rst_gnt", int'(gnt1_w[k] | gnt2_w[k]), 0);
         check_val("async_rst_wrap", int'(wrap_w[k]), 0);
      end
      @(negedge clk);
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int first_wrap;
      int wraps_b;
      int tog;
      m_thr[0] = 8;
      m_thr[1] = 255;
      rst = 1'b1;
      set_inputs(0, 0, 0, 0);
      init1 = '0; init2 = '0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      set_inputs(0, 0, 1, 1);
      cycle();
      cycle();

      // Single requester counts lane 1 up to the threshold, then reloads.
      init1 = 8'd0; init2 = 8'd1;
      first_wrap = -1;
      for (int i = 0; i < 14; i++) begin
         set_inputs(i == 0, 0, 1, 0);
         cycle();
         if (wrap_w[0] && first_wrap < 0) first_wrap = i + 1;
      end
      check_val("first_wrap_cycle", first_wrap, 11);

      // Both lanes requesting: alternating grants, lane 1 first after reload.
      for (int i = 0; i < 30; i++) begin
         set_inputs(0, 0, 1, 1);
         cycle();
      end
      set_inputs(0, 1, 0, 0);
      cycle();
      check_val("stop_to_idle", int'(state_w[0]), M_IDLE);

      // THRESH=255 instance wraps the counter FE, FF, 00 with no wrap pulse.
      init1 = 8'hFE; init2 = 8'h00;
      wraps_b = 0;
      for (int i = 0; i < 6; i++) begin
         set_inputs(i == 0, 0, 1, 0);
         cycle();
         wraps_b += int'(wrap_w[1]);
      end
      check_val("b_val1_after_wrap", int'(val1_w[1]), 8'h02);
      check_val("b_no_wrap_pulse", wraps_b, 0);
      set_inputs(0, 1, 0, 0);
      cycle();

      // stop in the very cycle the sum crosses the threshold.
      init1 = 8'd3; init2 = 8'd4;
      set_inputs(1, 0, 0, 0);
      cycle();
      for (int i = 0; i < 12 && m_mode[0] != M_IDLE; i++) begin
         set_inputs(0, (m_mode[0] == M_RUN && model_sum(0) > m_thr[0]), 1, 1);
         cycle();
      end
      check_val("stop_over_state", int'(state_w[0]), M_IDLE);
      check_val("stop_over_wrap", int'(wrap_w[0]), 0);
      check_val("stop_over_sum", int'(sum_w[0]), 9);

      // Init values already over threshold: RUN/RELOAD ping-pong.
      init1 = 8'd9; init2 = 8'd0;
      set_inputs(1, 0, 1, 1);
      cycle();
      cycle();
      tog = 0;
      for (int i = 0; i < 10; i++) begin
         set_inputs(0, 0, 1, 1);
         cycle();
         tog += int'(wrap_w[0]);
      end
      check_val("pingpong_wraps", tog, 5);
      set_inputs(0, 1, 0, 0);
      cycle();

      // Reset mid-run with val1=5, then start is needed again.
      init1 = 8'd5; init2 = 8'd0;
      set_inputs(1, 0, 0, 0);
      cycle();
      set_inputs(0, 0, 0, 0);
      cycle();
      cycle();
      check_val("pre_rst_val1", int'(val1_w[0]), 5);
      async_reset();
      for (int i = 0; i < 3; i++) begin
         set_inputs(0, 0, 1, 1);
         cycle();
      end
      check_val("idle_after_rst", int'(state_w[0]), M_IDLE);

      // Randomized traffic with occasional aborts and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            init1 = SIZE'($urandom_range(0, 12));
            init2 = SIZE'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 40) == 0) begin
            init1 = SIZE'($urandom_range(240, 255));
            init2 = SIZE'($urandom_range(0, 3));
         end
         set_inputs($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 80) == 0) async_reset();
         else cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
